ascon_init_engine: RTL and testbench
====================================

# ascon_init_engine

Sequential, parametrised Ascon initialization engine for the AEAD128, Hash256, XOF128 and CXOF128 modes. It selects the mode IV, registers key and nonce, and runs the 12-round p12 permutation internally at UNROLL rounds per clock. For AEAD128 it XORs the key into the tail of the state. It sits between the mode controller and the absorb/process stage and takes over initialization from the external p12 path, using a start/done handshake.

## Interface
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 3, 4, 6, 12. Any other value is a elaboration error.
- CNT_W, 4, round-counter width; must hold the value 12.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1, despite the name).
- start  in  1  request initialization; sampled only when in_ready=1.
- in_ready  out  1  engine idle, start will be accepted.
- sel_type  in  2  mode: 00 AEAD128, 01 Hash256, 10 XOF128, 11 CXOF128; sampled with start.
- key  in  128  AEAD key; sampled with start.
- nonce  in  128  AEAD nonce; sampled with start.
- out_valid  out  1  x0..x4 hold a completed initial state.
- out_ready  in  1  consumer accepts the state.
- x0, x1, x2, x3, x4  out  64 each  initialized state words.
- busy  out  1  permutation in progress.

## Operation
- The IV is selected from sel_type:
  - AEAD128: 00001000808c0001
  - Hash256: 0000080100cc0002
  - XOF128: 0000080000cc0003
  - CXOF128: 0000080000cc0004
- For every mode other than AEAD128, key and nonce are forced to 0 before the state is loaded.
- The initial state is x0=IV, x1=key[127:64], x2=key[63:0], x3=nonce[127:64], x4=nonce[63:0].
- The key is captured into an internal register at accept. Inputs may change freely after accept.
- Each round applies three steps in order:
  - Constant addition: x2 ^= c_r, where c_r = {(4'hf - r), r[3:0]} for r = 0..11. This gives f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b.
  - Ascon 5-bit S-box, bitsliced across the 64 columns.
  - Linear layer, using rotate-rights:
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
- All rotates are 64-bit. The round counter rc advances by UNROLL per cycle. Round k inside a cycle uses constant index rc+k.
- After round 11, AEAD128 XORs the captured key: x3 ^= key[127:64], x4 ^= key[63:0]. Other modes XOR nothing.
- FSM states and transitions:
  - IDLE -> PERM on start & in_ready.
  - PERM -> DONE on the cycle that completes round 11.
  - DONE -> IDLE on out_valid & out_ready.
- Output decode by state:
  - IDLE: in_ready=1.
  - PERM: busy=1.
  - DONE: out_valid=1.
- start is ignored while in PERM or DONE; no queuing.
- x0..x4 are registered. They update only on entry to DONE and hold until the next completion, including through IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, busy=0, out_valid=0, x0..x4=0, rc=0, and internal state and key registers 0.
- Accept occurs at edge E where start & in_ready. PERM is entered at E.
- N = 12/UNROLL, so N = 12, 6, 4, 3, 2, 1 for the legal UNROLL values.
- out_valid rises after edge E+N, giving a latency of N cycles from accept.
- in_ready is low from E through the edge that consumes the output.
- If out_ready=1 while out_valid=1, the state returns to IDLE on that edge, and in_ready=1 in the next cycle.
- Minimum start-to-start spacing is N+2 cycles with out_ready tied high.
- Back-pressure: while out_valid=1 and out_ready=0, the state and outputs are held indefinitely.
- A start asserted in the same cycle as the DONE handshake is not accepted, because in_ready=0.
- If rst_n asserts mid-PERM or mid-DONE, all registers clear asynchronously. The state is IDLE and outputs are 0 immediately, and no partial result is ever presented.
- Changing sel_type, key or nonce during PERM has no effect on the result.

## Test plan
- Reset check with UNROLL=1: hold rst_n=1 for 3 cycles, then release.
  - Expect in_ready=1, busy=0, out_valid=0, x0..x4=0.
  - Assert rst_n asynchronously mid-cycle and confirm the outputs clear before the next edge.
- Hash256 with UNROLL=1: start with sel_type=01, key=all-ones, nonce=all-ones.
  - Expect out_valid exactly 12 cycles after accept.
  - Expect x0..x4 equal to the golden model's p12(IV_hash, 0, 0, 0, 0), proving the non-AEAD key/nonce zeroing.
- AEAD128 sweep over UNROLL ∈ {1, 2, 3, 4, 6, 12}: key=000102…0f, nonce=101112…1f.
  - Latency must be 12, 6, 4, 3, 2, 1 cycles respectively.
  - x0..x4 must be identical across all builds and match the golden model, including the x3/x4 key XOR.
- Back-pressure: after completion, hold out_ready=0 for 20 cycles while toggling start, key and sel_type.
  - Outputs must be stable and out_valid=1 throughout; no new accept may occur.
  - Then raise out_ready for 1 cycle. Expect IDLE next cycle with x0..x4 unchanged.
- Input isolation: change key, nonce and sel_type on every cycle of PERM after a CXOF128 start.
  - The result must equal p12(0000080000cc0004, 0, 0, 0, 0).
- Mid-operation reset at round 5 with UNROLL=1, followed by an immediate XOF128 start.
  - Expect no out_valid from the aborted run.
  - The new result must arrive 12 cycles after the new accept and match the golden model.

Source files
------------

// File: rtl/ascon_init_engine_if.sv
// rtl/ascon_init_engine_if.sv - start/done handshake bundle for the Ascon initialization engine
//
// Purpose: groups the request side (start, in_ready, sel_type, key, nonce)
// and the result side (out_valid, out_ready, x0..x4, busy) of the engine.
//   master : mode controller / consumer (drives start, sel_type, key, nonce, out_ready)
//   slave  : ascon_init_engine (drives in_ready, out_valid, x0..x4, busy)

interface ascon_init_engine_if;
    logic         start;
    logic         in_ready;
    logic [1:0]   sel_type;
    logic [127:0] key;
    logic [127:0] nonce;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  x0;
    logic [63:0]  x1;
    logic [63:0]  x2;
    logic [63:0]  x3;
    logic [63:0]  x4;
    logic         busy;

    modport master (
        output start,
        output sel_type,
        output key,
        output nonce,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x0,
        input  x1,
        input  x2,
        input  x3,
        input  x4,
        input  busy
    );

    modport slave (
        input  start,
        input  sel_type,
        input  key,
        input  nonce,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x0,
        output x1,
        output x2,
        output x3,
        output x4,
        output busy
    );
endinterface

// File: rtl/ascon_init_engine.sv
// rtl/ascon_init_engine.sv - Ascon IV load + p12 initialization engine, UNROLL rounds per clock
//
// Purpose: on an accepted start, loads {IV, key, nonce} (key/nonce zeroed for
// the hash/XOF modes), runs the 12-round Ascon permutation at UNROLL rounds
// per cycle, XORs the key into x3/x4 for AEAD128 and presents x0..x4 until
// the consumer takes them.
// Parameters:
//   UNROLL : rounds per clock (1, 2, 3, 4, 6 or 12)
//   CNT_W  : round counter width, at least 4
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active HIGH despite the name
//   bus    : ascon_init_engine_if.slave (start/in_ready request side,
//            out_valid/out_ready result side, x0..x4, busy)

module ascon_init_engine #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ascon_init_engine_if.slave bus
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 ||
          UNROLL == 4 || UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
        $error("ascon_init_engine: UNROLL must be 1, 2, 3, 4, 6 or 12");
    end
    if (CNT_W < 4) begin : g_bad_cnt_w
        $error("ascon_init_engine: CNT_W must be able to hold 12");
    end

    localparam logic [63:0] IV_AEAD128 = 64'h00001000808c0001;
    localparam logic [63:0] IV_HASH256 = 64'h0000080100cc0002;
    localparam logic [63:0] IV_XOF128  = 64'h0000080000cc0003;
    localparam logic [63:0] IV_CXOF128 = 64'h0000080000cc0004;

    localparam logic [CNT_W-1:0] RC_STEP = CNT_W'(UNROLL);
    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(12);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PERM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One full Ascon round on the packed state {x0,x1,x2,x3,x4}, x0 in the MSBs.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] a0, a1, a2, a3, a4;
        logic [63:0] t0, t1, t2, t3, t4;
        a0 = s[319:256];
        a1 = s[255:192];
        a2 = s[191:128] ^ {56'd0, c};
        a3 = s[127:64];
        a4 = s[63:0];
        // Bitsliced 5-bit S-box: every bit column of the five words is one S-box.
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;
        // Linear diffusion layer
        a0 = a0 ^ ror64(a0, 19) ^ ror64(a0, 28);
        a1 = a1 ^ ror64(a1, 61) ^ ror64(a1, 39);
        a2 = a2 ^ ror64(a2, 1)  ^ ror64(a2, 6);
        a3 = a3 ^ ror64(a3, 10) ^ ror64(a3, 17);
        a4 = a4 ^ ror64(a4, 7)  ^ ror64(a4, 41);
        return {a0, a1, a2, a3, a4};
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_w;
    logic               busy_w;
    logic               out_valid_w;

    logic [319:0]       s_q;
    logic [127:0]       key_q;
    logic [CNT_W-1:0]   rc_q;
    logic [319:0]       result_q;

    logic               is_aead;
    logic [63:0]        iv_sel;
    logic [127:0]       key_m;
    logic [127:0]       nonce_m;
    logic               accept;
    logic [CNT_W-1:0]   rc_next;
    logic               last_cycle;
    logic [319:0]       perm_out;

    always_comb begin
        iv_sel = IV_AEAD128;
        case (bus.sel_type)
            2'b00:   iv_sel = IV_AEAD128;
            2'b01:   iv_sel = IV_HASH256;
            2'b10:   iv_sel = IV_XOF128;
            default: iv_sel = IV_CXOF128;
        endcase
    end

    // Hash/XOF modes start from an all-zero capacity; zeroing the captured key
    // as well makes the final key XOR a no-op for them without a mode flag.
    assign is_aead = (bus.sel_type == 2'b00);
    assign key_m   = is_aead ? bus.key   : '0;
    assign nonce_m = is_aead ? bus.nonce : '0;

    assign accept     = (state_q == ST_IDLE) && bus.start;
    assign rc_next    = rc_q + RC_STEP;
    assign last_cycle = (rc_next == RC_LAST);

    // Combinational chain of UNROLL rounds; round k uses constant index rc+k.
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [CNT_W-1:0] idx;
        logic [319:0]     s_in;
        logic [319:0]     s_out;
        assign idx = rc_q + CNT_W'(k);
        if (k == 0) begin : g_first
            assign s_in = s_q;
        end else begin : g_chain
            assign s_in = g_round[k-1].s_out;
        end
        assign s_out = ascon_round(s_in, {4'hf - idx[3:0], idx[3:0]});
    end
    assign perm_out = g_round[UNROLL-1].s_out;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_w  = 1'b0;
        busy_w      = 1'b0;
        out_valid_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_w = 1'b1;
                if (bus.start) begin
                    state_d = ST_PERM;
                end
            end
            ST_PERM: begin
                busy_w = 1'b1;
                if (last_cycle) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // result_q is only written on the PERM->DONE cycle, so a run aborted by
    // reset never exposes a partially permuted state.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s_q      <= '0;
            key_q    <= '0;
            rc_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            s_q   <= {iv_sel, key_m, nonce_m};
            key_q <= key_m;
            rc_q  <= '0;
        end else if (state_q == ST_PERM) begin
            s_q  <= perm_out;
            rc_q <= rc_next;
            if (last_cycle) begin
                result_q <= perm_out ^ {192'd0, key_q};
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.busy      = busy_w;
    assign bus.out_valid = out_valid_w;
    assign bus.x0        = result_q[319:256];
    assign bus.x1        = result_q[255:192];
    assign bus.x2        = result_q[191:128];
    assign bus.x3        = result_q[127:64];
    assign bus.x4        = result_q[63:0];

endmodule

// File: tb/tb_ascon_init_engine.sv
// tb/tb_ascon_init_engine.sv - directed bench for ascon_init_engine across all UNROLL builds

module tb_ascon_init_engine;

    localparam logic [63:0] IV_AEAD = 64'h00001000808c0001;
    localparam logic [63:0] IV_HASH = 64'h0000080100cc0002;
    localparam logic [63:0] IV_XOF  = 64'h0000080000cc0003;
    localparam logic [63:0] IV_CXOF = 64'h0000080000cc0004;

    // Ascon S-box table, S(0) in the top 5 bits.
    localparam logic [159:0] SBOX = {
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         t_start;
    logic [1:0]   t_sel;
    logic [127:0] t_key;
    logic [127:0] t_nonce;
    logic         t_out_ready;

    logic [5:0]   ov_v;
    logic [5:0]   ir_v;
    logic [5:0]   busy_v;
    logic [319:0] res [6];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 :
                           (g == 3) ? 4 : (g == 4) ? 6 : 12;
        ascon_init_engine_if bus_if ();
        assign bus_if.start     = t_start;
        assign bus_if.sel_type  = t_sel;
        assign bus_if.key       = t_key;
        assign bus_if.nonce     = t_nonce;
        assign bus_if.out_ready = t_out_ready;
        assign ov_v[g]   = bus_if.out_valid;
        assign ir_v[g]   = bus_if.in_ready;
        assign busy_v[g] = bus_if.busy;
        assign res[g]    = {bus_if.x0, bus_if.x1, bus_if.x2, bus_if.x3, bus_if.x4};
        ascon_init_engine #(.UNROLL(U), .CNT_W(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus_if)
        );
    end

    function automatic int exp_lat(input int g);
        case (g)
            0: return 12;
            1: return 6;
            2: return 4;
            3: return 3;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    // Reference round: S-box applied column by column through the lookup table.
    function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        logic [7:0]  c;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        c = {4'(15 - r), 4'(r)};
        x[2] = x[2] ^ {56'd0, c};
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[(31 - int'(col))*5 +: 5];
            y[0][b] = o[4];
            y[1][b] = o[3];
            y[2][b] = o[2];
            y[3][b] = o[1];
            y[4][b] = o[0];
        end
        y[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
        y[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
        y[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
        y[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
        y[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] ref_p12(input logic [319:0] s);
        logic [319:0] t;
        t = s;
        for (int r = 0; r < 12; r++) t = ref_round(t, r);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for unit 0 to be idle, issues one start and counts cycles to out_valid.
    task automatic run_u1(input logic [1:0] sel, input logic [127:0] k, input logic [127:0] n,
                          input logic rdy, input bit scramble, output int lat);
        int w;
        w = 0;
        t_out_ready = rdy;
        while (!ir_v[0] && w < 100) begin
            tick();
            w++;
        end
        n_cmp++;
        if (ir_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_wait: in_ready=%0b required 1", ir_v[0]);
        end
        t_sel   = sel;
        t_key   = k;
        t_nonce = n;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        lat = 0;
        while (!ov_v[0] && lat < 40) begin
            if (scramble) begin
                t_key   = {$urandom, $urandom, $urandom, $urandom};
                t_nonce = {$urandom, $urandom, $urandom, $urandom};
                t_sel   = 2'($urandom);
                t_start = 1'($urandom);
            end
            tick();
            lat++;
        end
        t_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        t_start = 1'b0;
        t_sel = 2'b00;
        t_key = '0;
        t_nonce = '0;
        t_out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        for (int g = 0; g < 6; g++) begin
            n_cmp++;
            if (ir_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || ov_v[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: in_ready=%0b busy=%0b out_valid=%0b required 1/0/0",
                         g, ir_v[g], busy_v[g], ov_v[g]);
            end
            n_cmp++;
            if (res[g] !== 320'd0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got %h required 0", g, res[g]);
            end
        end
        // Async assert mid-PERM: outputs must clear before the next edge.
        t_sel = 2'b01;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_busy: busy=%0b required 1", busy_v[0]);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (busy_v[0] !== 1'b0 || ir_v[0] !== 1'b1 || ov_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: busy=%0b in_ready=%0b out_valid=%0b required 0/1/0",
                     busy_v[0], ir_v[0], ov_v[0]);
        end
        tick();
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_hash();
        int lat;
        logic [319:0] exp_s;
        exp_s = ref_p12({IV_HASH, 256'd0});
        run_u1(2'b01, '1, '1, 1'b1, 1'b0, lat);
        n_cmp++;
        if (lat != 12) begin
            n_bad++;
            $display("FAIL hash_latency: got %0d required 12", lat);
        end
        n_cmp++;
        if (res[0] !== exp_s) begin
            n_bad++;
            $display("FAIL hash_state: got %h required %h", res[0], exp_s);
        end
        tick();
        n_cmp++;
        if (ir_v[0] !== 1'b1 || ov_v[0] !== 1'b0 || res[0] !== exp_s) begin
            n_bad++;
            $display("FAIL hash_release: in_ready=%0b out_valid=%0b state %h required 1/0/%h",
                     ir_v[0], ov_v[0], res[0], exp_s);
        end
    endtask

    task automatic test_aead_sweep();
        int lat [6];
        int w;
        int cyc;
        logic [127:0] k;
        logic [127:0] n;
        logic [319:0] exp_s;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        n = 128'h101112131415161718191a1b1c1d1e1f;
        exp_s = ref_p12({IV_AEAD, k, n}) ^ {192'd0, k};
        w = 0;
        while (ir_v !== 6'h3f && w < 50) begin
            tick();
            w++;
        end
        t_out_ready = 1'b0;
        t_sel = 2'b00;
        t_key = k;
        t_nonce = n;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        for (int g = 0; g < 6; g++) lat[g] = -1;
        cyc = 0;
        repeat (16) begin
            tick();
            cyc++;
            for (int g = 0; g < 6; g++) if (ov_v[g] && lat[g] < 0) lat[g] = cyc;
        end
        for (int g = 0; g < 6; g++) begin
            n_cmp++;
            if (lat[g] != exp_lat(g)) begin
                n_bad++;
                $display("FAIL aead_latency[%0d]: got %0d required %0d", g, lat[g], exp_lat(g));
            end
            n_cmp++;
            if (res[g] !== exp_s) begin
                n_bad++;
                $display("FAIL aead_state[%0d]: got %h required %h", g, res[g], exp_s);
            end
        end
        t_out_ready = 1'b1;
        tick();
        n_cmp++;
        if (ir_v !== 6'h3f) begin
            n_bad++;
            $display("FAIL aead_release: in_ready=%b required 111111", ir_v);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [127:0] k;
        logic [127:0] n;
        logic [319:0] exp_s;
        k = 128'h0f0e0d0c0b0a09080706050403020100;
        n = 128'hdeadbeef00112233445566778899aabb;
        exp_s = ref_p12({IV_AEAD, k, n}) ^ {192'd0, k};
        run_u1(2'b00, k, n, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat != 12) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d required 12", lat);
        end
        for (int i = 0; i < 20; i++) begin
            t_start = i[0];
            t_key = ~t_key;
            t_sel = 2'(i);
            tick();
            n_cmp++;
            if (ov_v[0] !== 1'b1 || ir_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || res[0] !== exp_s) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%0b in_ready=%0b busy=%0b state %h required 1/0/0/%h",
                         i, ov_v[0], ir_v[0], busy_v[0], res[0], exp_s);
            end
        end
        // Start held high across the handshake edge must not be taken.
        t_start = 1'b1;
        t_out_ready = 1'b1;
        tick();
        t_out_ready = 1'b0;
        t_start = 1'b0;
        n_cmp++;
        if (ir_v[0] !== 1'b1 || ov_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b busy=%0b required 1/0/0",
                     ir_v[0], ov_v[0], busy_v[0]);
        end
        n_cmp++;
        if (res[0] !== exp_s) begin
            n_bad++;
            $display("FAIL bp_state_kept: got %h required %h", res[0], exp_s);
        end
        t_out_ready = 1'b1;
    endtask

    task automatic test_input_isolation();
        int lat;
        logic [319:0] exp_s;
        exp_s = ref_p12({IV_CXOF, 256'd0});
        run_u1(2'b11, 128'h55aa55aa55aa55aa55aa55aa55aa55aa, 128'h1234, 1'b1, 1'b1, lat);
        n_cmp++;
        if (lat != 12) begin
            n_bad++;
            $display("FAIL iso_latency: got %0d required 12", lat);
        end
        n_cmp++;
        if (res[0] !== exp_s) begin
            n_bad++;
            $display("FAIL iso_state: got %h required %h", res[0], exp_s);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int w;
        int lat;
        logic [319:0] exp_s;
        exp_s = ref_p12({IV_XOF, 256'd0});
        t_out_ready = 1'b1;
        w = 0;
        while (!ir_v[0] && w < 50) begin
            tick();
            w++;
        end
        t_sel = 2'b00;
        t_key = 128'h000102030405060708090a0b0c0d0e0f;
        t_nonce = 128'h101112131415161718191a1b1c1d1e1f;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (busy_v[0] !== 1'b1 || ov_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_pre: busy=%0b out_valid=%0b required 1/0", busy_v[0], ov_v[0]);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (busy_v[0] !== 1'b0 || ov_v[0] !== 1'b0 || ir_v[0] !== 1'b1 || res[0] !== 320'd0) begin
            n_bad++;
            $display("FAIL midrst_clear: busy=%0b out_valid=%0b in_ready=%0b state %h required 0/0/1/0",
                     busy_v[0], ov_v[0], ir_v[0], res[0]);
        end
        t_sel = 2'b10;
        t_key = '1;
        t_nonce = '1;
        t_start = 1'b1;
        #1;
        rst_n = 1'b0;
        tick();
        t_start = 1'b0;
        lat = 0;
        while (!ov_v[0] && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 12) begin
            n_bad++;
            $display("FAIL midrst_latency: got %0d required 12", lat);
        end
        n_cmp++;
        if (res[0] !== exp_s) begin
            n_bad++;
            $display("FAIL midrst_state: got %h required %h", res[0], exp_s);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_hash();
        test_aead_sweep();
        test_back_pressure();
        test_input_isolation();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
